// File: rtl/pkt_err_filter_fifo.sv
// pkt_err_filter_fifo: store-and-forward packet FIFO on a 16-bit sop/eop
// stream. Each packet is held until its eop arrives. It is then released to
// the output, or dropped if a non-first word matched ERR_WORD or the packet
// did not fit in the buffer.
module pkt_err_filter_fifo #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] ERR_WORD = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic [15:0] din,
  input  logic        din_eop,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic [15:0] dout,
  output logic        dout_eop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } wr_state_t;

  // Storage: {sop, eop, data} per word.
  logic [17:0] mem [DEPTH];

  wr_state_t   state_q, state_d;
  logic        bad_q, bad_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic        dout_vld_q, dout_vld_d;
  logic        dout_sop_q, dout_sop_d;
  logic        dout_eop_q, dout_eop_d;
  logic [15:0] dout_q, dout_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [17:0]   mem_wdata;
  logic [17:0]   mem_rdata;

  logic          full_cur;
  logic          full_sop;
  logic          is_err;
  logic          pkt_bad;
  logic [PW-1:0] sop_next;
  logic [PW-1:0] inc_next;
  logic          rd_en;

  // Write side: track the packet being received and decide commit or discard.
  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q[AW-1:0];
    mem_wdata   = {din_sop, din_eop, din};
    pkt_bad     = bad_q;

    // Occupancy seen by a continuation word counts the open packet; a sop
    // restarts at wr_commit, so its room is measured from there.
    full_cur = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    full_sop = ((wr_commit_q - rd_ptr_q) == DEPTH_P);
    is_err   = (din == ERR_WORD);
    sop_next = full_sop ? wr_commit_q : (wr_commit_q + ONE_P);
    inc_next = full_cur ? wr_ptr_q : (wr_ptr_q + ONE_P);

    if (din_vld) begin
      if (din_sop) begin
        // A sop always starts fresh from the last committed position, which
        // also throws away a previous packet that never saw its eop.
        bad_d     = full_sop;
        mem_we    = !full_sop;
        mem_waddr = wr_commit_q[AW-1:0];
        wr_ptr_d  = sop_next;
        if (din_eop) begin
          // Single-word packet: the first word is never marker-checked.
          if (!full_sop) begin
            wr_commit_d = sop_next;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_IN_PKT;
        end
      end else if (state_q == S_IN_PKT) begin
        pkt_bad = bad_q | is_err | full_cur;
        bad_d   = pkt_bad;
        mem_we  = !full_cur;
        if (din_eop) begin
          if (!pkt_bad) begin
            wr_ptr_d    = inc_next;
            wr_commit_d = inc_next;
          end else begin
            wr_ptr_d = wr_commit_q;
          end
          state_d = S_IDLE;
        end else begin
          wr_ptr_d = inc_next;
        end
      end
    end
  end

  // Read side: stream committed words out, one per cycle, zeroed when idle.
  always_comb begin
    mem_rdata  = mem[rd_ptr_q[AW-1:0]];
    rd_en      = (rd_ptr_q != wr_commit_q);
    rd_ptr_d   = rd_en ? (rd_ptr_q + ONE_P) : rd_ptr_q;
    dout_vld_d = rd_en;
    dout_sop_d = rd_en & mem_rdata[17];
    dout_eop_d = rd_en & mem_rdata[16];
    dout_d     = rd_en ? mem_rdata[15:0] : 16'h0000;
  end

  // Buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bad_q       <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      dout_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      bad_q       <= bad_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      dout_vld_q  <= dout_vld_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      dout_q      <= dout_d;
    end
  end

  assign dout_vld = dout_vld_q;
  assign dout_sop = dout_sop_q;
  assign dout_eop = dout_eop_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_pkt_err_filter_fifo.sv
// Scoreboard bench for pkt_err_filter_fifo (DEPTH=64 so overflow is reachable).
module tb_pkt_err_filter_fifo;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic [15:0] dout;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [17:0] sb [$];
  bit          mon_en = 1'b0;
  bit          in_out_pkt = 1'b0;
  bit          lat_armed = 1'b0;
  int          lat_expect = 0;

  pkt_err_filter_fifo #(
    .DEPTH    (DEPTH),
    .ERR_WORD (16'h0001)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din      (din),
    .din_eop  (din_eop),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout     (dout),
    .dout_eop (dout_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: compare every valid word against the scoreboard, require
  // idle outputs to be zero, and forbid gaps inside an output packet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_out_pkt) check("no_gap", {31'd0, dout_vld}, 32'd1);
      if (dout_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {14'd0, dout_sop, dout_eop, dout}, 32'hffffffff);
        end else begin
          logic [17:0] e;
          e = sb.pop_front();
          check("word", {14'd0, dout_sop, dout_eop, dout}, {14'd0, e});
          $display("out sop=%0d eop=%0d data=0x%04h", dout_sop, dout_eop, dout);
        end
        if (dout_sop && lat_armed) begin
          check("latency", cyc, lat_expect);
          lat_armed = 1'b0;
        end
        in_out_pkt = !dout_eop;
      end else begin
        check("idle_zero", {14'd0, dout_sop, dout_eop, dout}, 32'd0);
        in_out_pkt = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
      din     = 16'h0000;
    end
  endtask

  // Drive an n-word packet with values i+1; word bad_idx carries the marker.
  task automatic send_pkt(input int n, input int bad_idx, input bit use_eop,
                          input bit keep, input bit arm_lat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_vld = 1'b1;
      din_sop = (i == 0);
      din_eop = use_eop && (i == n - 1);
      din     = (i == bad_idx) ? 16'h0001 : 16'(i + 1);
      if (keep) sb.push_back({din_sop, din_eop, din});
      if (arm_lat && din_eop) begin
        lat_expect = cyc + 2;
        lat_armed  = 1'b1;
      end
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    idle(1);
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    idle(5);
    check(tag, sb.size(), 0);
    check({tag, "_lat_seen"}, {31'd0, lat_armed}, 32'd0);
    lat_armed = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles: outputs must be zero throughout.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_out", {13'd0, dout_vld, dout_sop, dout_eop, dout}, 32'd0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(5);

    // Good 60-word packet, first word one cycle after the eop edge.
    send_pkt(60, -1, 1'b1, 1'b1, 1'b1);
    drain("good60");

    // Marker at index 19 condemns the whole packet.
    send_pkt(60, 19, 1'b1, 1'b0, 1'b0);
    drain("marker_drop");

    // Four packets, even ones marked: only 1 and 3 come out.
    for (int p = 0; p < 4; p++) begin
      send_pkt(60, (p % 2 == 0) ? 19 : -1, 1'b1, (p % 2 == 1), 1'b0);
      idle(10);
    end
    drain("sequence");

    // Single-word packet equal to the marker is exempt.
    send_pkt(1, 0, 1'b1, 1'b1, 1'b1);
    drain("first_word_exempt");

    // Marker on the eop word drops the packet.
    send_pkt(8, 7, 1'b1, 1'b0, 1'b0);
    drain("marker_on_eop");

    // Packet without eop is abandoned by the next sop.
    send_pkt(5, -1, 1'b0, 1'b0, 1'b0);
    send_pkt(6, -1, 1'b1, 1'b1, 1'b0);
    drain("missing_eop");

    // Overflow: 70 words into a 64-deep buffer, then a good 10-word packet.
    send_pkt(70, -1, 1'b1, 1'b0, 1'b0);
    send_pkt(10, -1, 1'b1, 1'b1, 1'b1);
    drain("overflow");

    // Reset in the middle of a read: outputs clear at once, data is lost.
    send_pkt(20, -1, 1'b1, 1'b1, 1'b0);
    idle(5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {13'd0, dout_vld, dout_sop, dout_eop, dout}, 32'd0);
    sb.delete();
    in_out_pkt = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    send_pkt(5, -1, 1'b1, 1'b1, 1'b1);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
